pipeline_hazard_sequencer: RTL and testbench

Multi-cycle stall/flush sequencer for the 5-stage RISC-V pipeline. It arbitrates four stall and flush sources: data-memory wait, load-use hazard, branch flush and debug halt. It drives the enable and reset controls of the PC and the FE/DE, DE/EX and EX/MEM pipeline registers. It also times out stuck memory accesses and counts stall cycles.

---
 rtl/pipeline_hazard_sequencer_if.sv | 48 ++++
 rtl/pipeline_hazard_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_pipeline_hazard_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_sequencer_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_sequencer_if
// Bundles the hazard request lines and the pipeline-register control lines
// exchanged between the hazard sequencer and the 5-stage pipeline datapath.
//
// Signals:
//   Mem_Req, Mem_Ack, Load_Use_Req, Br_Flush_Req, Halt_Req : hazard requests
//   PC_Fetch_EN, FE_DE_Reg_EN, DE_EX_Reg_EN, EX_MEM_Reg_EN : register enables
//   FE_DE_Reg_RST, DE_EX_Reg_RST, EX_MEM_Reg_RST            : register flushes
//   Busy, Timeout_Err, Stall_Cnt[CNT_W]                     : status
//
// Modports:
//   master : the sequencer (consumes requests, drives controls/status)
//   slave  : the pipeline side (drives requests, consumes controls/status)
// -----------------------------------------------------------------------------
interface pipeline_hazard_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             Mem_Req;
    logic             Mem_Ack;
    logic             Load_Use_Req;
    logic             Br_Flush_Req;
    logic             Halt_Req;
    logic             PC_Fetch_EN;
    logic             FE_DE_Reg_EN;
    logic             DE_EX_Reg_EN;
    logic             EX_MEM_Reg_EN;
    logic             FE_DE_Reg_RST;
    logic             DE_EX_Reg_RST;
    logic             EX_MEM_Reg_RST;
    logic             Busy;
    logic             Timeout_Err;
    logic [CNT_W-1:0] Stall_Cnt;

    modport master (
        input  Mem_Req, Mem_Ack, Load_Use_Req, Br_Flush_Req, Halt_Req,
        output PC_Fetch_EN, FE_DE_Reg_EN, DE_EX_Reg_EN, EX_MEM_Reg_EN,
        output FE_DE_Reg_RST, DE_EX_Reg_RST, EX_MEM_Reg_RST,
        output Busy, Timeout_Err, Stall_Cnt
    );

    modport slave (
        output Mem_Req, Mem_Ack, Load_Use_Req, Br_Flush_Req, Halt_Req,
        input  PC_Fetch_EN, FE_DE_Reg_EN, DE_EX_Reg_EN, EX_MEM_Reg_EN,
        input  FE_DE_Reg_RST, DE_EX_Reg_RST, EX_MEM_Reg_RST,
        input  Busy, Timeout_Err, Stall_Cnt
    );
endinterface

// File: rtl/pipeline_hazard_sequencer.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_sequencer
// Stall/flush sequencer for a 5-stage RISC-V pipeline. Arbitrates data-memory
// wait, load-use hazard, branch flush and debug halt, and drives the enables
// and flushes of the PC and the FE/DE, DE/EX and EX/MEM registers. Stuck
// memory accesses time out into a sticky error HALT that only rst leaves.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : pipeline_hazard_sequencer_if.master (requests in, controls and
//          Busy / Timeout_Err / Stall_Cnt out)
//
// Build option:
//   STALL_PERF_CNT_EN : when defined, Stall_Cnt counts every cycle with any
//                       enable low or any flush high (saturating); when
//                       undefined, no counter exists and Stall_Cnt reads 0.
// -----------------------------------------------------------------------------
module pipeline_hazard_sequencer #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int MEM_TIMEOUT       = 255,
    parameter int TO_W              = 8,
    parameter int CNT_W             = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    pipeline_hazard_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_RUN, S_MEM_WAIT, S_LOAD_STALL, S_FLUSH, S_HALT
    } state_t;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);
    localparam logic [3:0]      LS_LOAD  = 4'(LOAD_STALL_CYCLES - 1);
    localparam logic [3:0]      FL_LOAD  = 4'(FLUSH_CYCLES - 1);

    state_t          r_state, w_next;
    logic [TO_W-1:0] r_wait_cnt, w_wait_nxt;
    logic [3:0]      r_seq_cnt, w_seq_nxt;   // shared by LOAD_STALL and FLUSH
    logic            r_timeout, w_timeout_nxt;
    logic            w_mem_stall;
    logic            w_en_pc, w_en_fd, w_en_de, w_en_em;
    logic            w_rst_fd, w_rst_de, w_rst_em;

    // An access acknowledged in its request cycle never stalls.
    assign w_mem_stall = bus.Mem_Req & ~bus.Mem_Ack;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_wait_cnt <= '0;
            r_seq_cnt  <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_nxt;
            r_seq_cnt  <= w_seq_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_next        = r_state;
        w_wait_nxt    = r_wait_cnt;
        w_seq_nxt     = r_seq_cnt;
        w_timeout_nxt = r_timeout;
        unique case (r_state)
            S_RUN: begin
                if (w_mem_stall) begin
                    w_wait_nxt = TO_W'(1);
                    w_next     = S_MEM_WAIT;
                end else if (bus.Load_Use_Req) begin
                    // A single-cycle bubble is fully handled by the RUN cycle.
                    if (LOAD_STALL_CYCLES > 1) begin
                        w_seq_nxt = LS_LOAD;
                        w_next    = S_LOAD_STALL;
                    end
                end else if (bus.Br_Flush_Req) begin
                    if (FLUSH_CYCLES > 1) begin
                        w_seq_nxt = FL_LOAD;
                        w_next    = S_FLUSH;
                    end
                end else if (bus.Halt_Req) begin
                    w_next = S_HALT;
                end
            end
            S_MEM_WAIT: begin
                if (bus.Mem_Ack) begin
                    w_next = S_RUN;
                end else if (r_wait_cnt == TO_LIMIT) begin
                    w_timeout_nxt = 1'b1;
                    w_next        = S_HALT;
                end else begin
                    w_wait_nxt = r_wait_cnt + TO_W'(1);
                end
            end
            S_LOAD_STALL, S_FLUSH: begin
                w_seq_nxt = r_seq_cnt - 4'd1;
                if (r_seq_cnt == 4'd1) begin
                    w_next = S_RUN;
                end
            end
            S_HALT: begin
                // A timed-out access leaves the core halted until rst.
                if (!bus.Halt_Req && !r_timeout) begin
                    w_next = S_RUN;
                end
            end
            default: w_next = S_RUN;
        endcase
    end

    // Output logic: Mealy in RUN, Moore elsewhere, forced to defaults in rst
    always_comb begin
        w_en_pc  = 1'b1;
        w_en_fd  = 1'b1;
        w_en_de  = 1'b1;
        w_en_em  = 1'b1;
        w_rst_fd = 1'b0;
        w_rst_de = 1'b0;
        w_rst_em = 1'b0;
        if (!rst) begin
            unique case (r_state)
                S_RUN: begin
                    if (w_mem_stall || (!bus.Load_Use_Req && !bus.Br_Flush_Req
                                        && bus.Halt_Req)) begin
                        {w_en_pc, w_en_fd, w_en_de, w_en_em} = 4'b0000;
                    end else if (bus.Load_Use_Req) begin
                        {w_en_pc, w_en_fd, w_en_de} = 3'b000;
                        w_rst_em = 1'b1;
                    end else if (bus.Br_Flush_Req) begin
                        w_rst_fd = 1'b1;
                        w_rst_de = 1'b1;
                    end
                end
                S_LOAD_STALL: begin
                    {w_en_pc, w_en_fd, w_en_de} = 3'b000;
                    w_rst_em = 1'b1;
                end
                S_FLUSH: begin
                    w_rst_fd = 1'b1;
                    w_rst_de = 1'b1;
                end
                default: begin
                    // MEM_WAIT and HALT freeze everything.
                    {w_en_pc, w_en_fd, w_en_de, w_en_em} = 4'b0000;
                end
            endcase
        end
    end

    assign bus.PC_Fetch_EN    = w_en_pc;
    assign bus.FE_DE_Reg_EN   = w_en_fd;
    assign bus.DE_EX_Reg_EN   = w_en_de;
    assign bus.EX_MEM_Reg_EN  = w_en_em;
    assign bus.FE_DE_Reg_RST  = w_rst_fd;
    assign bus.DE_EX_Reg_RST  = w_rst_de;
    assign bus.EX_MEM_Reg_RST = w_rst_em;
    assign bus.Busy           = (r_state != S_RUN) && !rst;
    assign bus.Timeout_Err    = r_timeout;

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_stalled;

    assign w_stalled = ~(w_en_pc & w_en_fd & w_en_de & w_en_em)
                     | w_rst_fd | w_rst_de | w_rst_em;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stalled && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.Stall_Cnt = r_stall_cnt;
`else
    assign bus.Stall_Cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Two sequencer configurations share one stimulus stream. A behavioural model
// per configuration predicts each cycle's outputs; predictions are queued and
// a negedge monitor compares them against the DUT outputs.
module tb_pipeline_hazard_sequencer;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mr = 1'b0, ma = 1'b0, lu = 1'b0, bf = 1'b0, hr = 1'b0;

    always #5 clk = ~clk;

    pipeline_hazard_sequencer_if #(.CNT_W(CW)) if0 ();
    pipeline_hazard_sequencer_if #(.CNT_W(CW)) if1 ();

    assign if0.Mem_Req = mr;  assign if1.Mem_Req = mr;
    assign if0.Mem_Ack = ma;  assign if1.Mem_Ack = ma;
    assign if0.Load_Use_Req = lu;  assign if1.Load_Use_Req = lu;
    assign if0.Br_Flush_Req = bf;  assign if1.Br_Flush_Req = bf;
    assign if0.Halt_Req = hr;  assign if1.Halt_Req = hr;

    pipeline_hazard_sequencer #(
        .LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1), .MEM_TIMEOUT(5), .TO_W(8), .CNT_W(CW)
    ) dut0 (.clk(clk), .rst(rst), .bus(if0));

    pipeline_hazard_sequencer #(
        .LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(4), .MEM_TIMEOUT(9), .TO_W(8), .CNT_W(CW)
    ) dut1 (.clk(clk), .rst(rst), .bus(if1));

    typedef struct {
        logic [6:0]    ctl;   // {pc,fd,de,em enables, fd,de,em flushes}
        logic          busy;
        logic          terr;
        logic [CW-1:0] sc;
        bit            chk_regs;
        string         tag;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int n_chk = 0;
    int n_pass = 0;

    // Behavioural model state: remaining work per hazard kind, not FSM states.
    int P_L[2]  = '{1, 3};
    int P_F[2]  = '{1, 4};
    int P_TO[2] = '{5, 9};
    int m_wait[2] = '{0, 0};   // 0: no outstanding wait, else cycles waited
    int m_bub[2]  = '{0, 0};   // extra bubble cycles still owed
    int m_fl[2]   = '{0, 0};   // extra flush cycles still owed
    bit m_halt[2] = '{0, 0};
    bit m_err[2]  = '{0, 0};
    int m_sc[2]   = '{0, 0};

    task automatic model_step(input int k, input string tag);
        exp_t e;
        bit [3:0] en;
        bit [2:0] rr;
        en = 4'b1111;
        rr = 3'b000;
        e.busy = !rst && (m_wait[k] != 0 || m_bub[k] != 0 || m_fl[k] != 0 || m_halt[k]);
        e.terr = m_err[k];
        e.sc = CW'(m_sc[k]);
        e.chk_regs = !rst;
        e.tag = tag;
        if (rst) begin
            m_wait[k] = 0; m_bub[k] = 0; m_fl[k] = 0;
            m_halt[k] = 0; m_err[k] = 0; m_sc[k] = 0;
        end else begin
            if (m_wait[k] != 0) begin
                en = 4'b0000;
                if (ma) m_wait[k] = 0;
                else if (m_wait[k] == P_TO[k]) begin
                    m_wait[k] = 0; m_err[k] = 1; m_halt[k] = 1;
                end else m_wait[k]++;
            end else if (m_bub[k] != 0) begin
                en = 4'b0001; rr = 3'b001; m_bub[k]--;
            end else if (m_fl[k] != 0) begin
                rr = 3'b110; m_fl[k]--;
            end else if (m_halt[k]) begin
                en = 4'b0000;
                if (!hr && !m_err[k]) m_halt[k] = 0;
            end else if (mr && !ma) begin
                en = 4'b0000; m_wait[k] = 1;
            end else if (lu) begin
                en = 4'b0001; rr = 3'b001; m_bub[k] = P_L[k] - 1;
            end else if (bf) begin
                rr = 3'b110; m_fl[k] = P_F[k] - 1;
            end else if (hr) begin
                en = 4'b0000; m_halt[k] = 1;
            end
            if ((en != 4'b1111 || rr != 3'b000) && m_sc[k] < (1 << CW) - 1) m_sc[k]++;
        end
        e.ctl = {en, rr};
`ifndef STALL_PERF_CNT_EN
        e.sc = '0;
`endif
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic step(input bit i_mr, input bit i_ma, input bit i_lu, input bit i_bf,
                        input bit i_hr, input bit i_rs, input string tag);
        mr = i_mr; ma = i_ma; lu = i_lu; bf = i_bf; hr = i_hr; rst = i_rs;
        model_step(0, tag);
        model_step(1, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, tag);
    endtask

    task automatic compare(input int k, input exp_t e, input logic [6:0] actl,
                           input logic abusy, input logic aterr, input logic [CW-1:0] asc);
        bit ok;
        ok = (actl === e.ctl) && (abusy === e.busy);
        if (e.chk_regs) ok = ok && (aterr === e.terr) && (asc === e.sc);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s dut%0d: got ctl=%b busy=%b terr=%b cnt=%0d, expected ctl=%b busy=%b terr=%b cnt=%0d",
                      e.tag, k, actl, abusy, aterr, asc, e.ctl, e.busy, e.terr, e.sc);
    endtask

    // Monitor: every cycle the sequencer presents a full control word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                compare(0, e, {if0.PC_Fetch_EN, if0.FE_DE_Reg_EN, if0.DE_EX_Reg_EN, if0.EX_MEM_Reg_EN,
                               if0.FE_DE_Reg_RST, if0.DE_EX_Reg_RST, if0.EX_MEM_Reg_RST},
                        if0.Busy, if0.Timeout_Err, if0.Stall_Cnt);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                compare(1, e, {if1.PC_Fetch_EN, if1.FE_DE_Reg_EN, if1.DE_EX_Reg_EN, if1.EX_MEM_Reg_EN,
                               if1.FE_DE_Reg_RST, if1.DE_EX_Reg_RST, if1.EX_MEM_Reg_RST},
                        if1.Busy, if1.Timeout_Err, if1.Stall_Cnt);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, 0, 1, "reset");
        step(1, 0, 1, 1, 1, 1, "reset_ignores_req");
        idle(2, "idle_after_reset");

        step(0, 0, 1, 0, 0, 0, "load_use_pulse");
        idle(4, "after_load_use");

        step(1, 1, 0, 0, 0, 0, "mem_ack_same_cycle");
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0, 0, "mem_wait_flush_held");
        step(1, 1, 0, 1, 0, 0, "mem_ack");
        step(0, 0, 0, 1, 0, 0, "flush_after_mem");
        idle(5, "after_flush");

        for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0, 0, "mem_timeout");
        idle(3, "timeout_halt_stuck");
        step(0, 0, 0, 0, 0, 1, "reset_clears_timeout");
        idle(2, "after_timeout_reset");

        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 1, 0, "all_three_req");
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 0, "flush_and_halt");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, "halt_only");
        idle(3, "halt_release");

        step(0, 0, 0, 1, 0, 0, "flush_start");
        idle(1, "flush_cycle2");
        step(0, 0, 0, 0, 0, 1, "reset_mid_flush");
        idle(3, "after_flush_reset");

        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(99) < 25, $urandom_range(99) < 50, $urandom_range(99) < 15,
                 $urandom_range(99) < 15, $urandom_range(99) < 10, $urandom_range(99) < 2,
                 "random");
        end
        idle(3, "drain");

        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (q0.size() == 0 && q1.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d/%0d pending, expected 0/0", q0.size(), q1.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
